// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
// The latched-request struct is sized by MEM_AW/MEM_DW; instance widths must not exceed them.
package mem_arb_pkg;

    localparam int MEM_AW      = 64;
    localparam int MEM_DW      = 64;
    localparam int MEM_MW      = MEM_DW / 8;
    localparam int LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef enum logic {
        SRC_IFU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    typedef struct packed {
        src_e              src;
        logic [MEM_AW-1:0] addr;
        logic              wen;
        logic [MEM_DW-1:0] wdata;
        logic [MEM_MW-1:0] wmask;
    } req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: IFU and LSU request/response channels plus the memory port.
// slave is the arbiter side; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [AW-1:0]     ifu_addr;
    logic              ifu_rsp_valid;
    logic [DW-1:0]     ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [AW-1:0]     lsu_addr;
    logic              lsu_wen;
    logic [DW-1:0]     lsu_wdata;
    logic [DW/8-1:0]   lsu_wmask;
    logic              lsu_rsp_valid;
    logic [DW-1:0]     lsu_rdata;

    logic              mem_ren;
    logic [AW-1:0]     mem_raddr;
    logic              mem_wen;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wmask;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between IFU and LSU.
// MEM_ARB_RR_EN: round-robin on last_grant; otherwise fixed LSU priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
`ifdef MEM_ARB_RR_EN
    input  src_e last_grant,
`endif
    output logic grant_ifu,
    output logic grant_lsu
);

    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (ifu_valid && lsu_valid) begin
            // Contention goes to whichever side did not win last time.
            if (last_grant == SRC_IFU) begin
                grant_lsu = 1'b1;
            end else begin
                grant_ifu = 1'b1;
            end
        end else begin
            grant_ifu = ifu_valid;
            grant_lsu = lsu_valid;
        end
`else
        grant_lsu = lsu_valid;
        grant_ifu = ifu_valid & ~lsu_valid;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU (read/write), one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int AW      = MEM_AW,
    parameter int DW      = MEM_DW
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [MEM_DW-1:0] rdata_q, rdata_d;
    logic              grant_ifu, grant_lsu;

`ifdef MEM_ARB_RR_EN
    src_e              last_grant_q, last_grant_d;
`endif

    mem_arb_pick u_pick (
        .ifu_valid  (bus.ifu_req_valid),
        .lsu_valid  (bus.lsu_req_valid),
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .grant_ifu  (grant_ifu),
        .grant_lsu  (grant_lsu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            rdata_q      <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= SRC_IFU;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            rdata_q      <= rdata_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        bus.ifu_req_ready = 1'b0;
        bus.lsu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        bus.ifu_rdata     = '0;
        bus.lsu_rdata     = '0;
        bus.mem_ren       = 1'b0;
        bus.mem_wen       = 1'b0;
        bus.mem_raddr     = '0;
        bus.mem_waddr     = '0;
        bus.mem_wdata     = '0;
        bus.mem_wmask     = '0;

        case (state_q)
            IDLE: begin
                bus.ifu_req_ready = grant_ifu;
                bus.lsu_req_ready = grant_lsu;
                if (grant_ifu || grant_lsu) begin
                    if (grant_lsu) begin
                        req_d.src   = SRC_LSU;
                        req_d.addr  = MEM_AW'(bus.lsu_addr);
                        req_d.wen   = bus.lsu_wen;
                        req_d.wdata = MEM_DW'(bus.lsu_wdata);
                        req_d.wmask = MEM_MW'(bus.lsu_wmask);
                    end else begin
                        req_d.src   = SRC_IFU;
                        req_d.addr  = MEM_AW'(bus.ifu_addr);
                        req_d.wen   = 1'b0;
                        req_d.wdata = '0;
                        req_d.wmask = '0;
                    end
`ifdef MEM_ARB_RR_EN
                    last_grant_d = req_d.src;
`endif
                    cnt_d   = CNT_LOAD;
                    rdata_d = '0;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                bus.mem_ren = ~req_q.wen;
                bus.mem_wen = req_q.wen;
                // mem_rdata is combinational from mem_raddr, so capture it here.
                rdata_d     = req_q.wen ? '0 : MEM_DW'(bus.mem_rdata);
                state_d     = RESP;
            end
            RESP: begin
                if (req_q.src == SRC_LSU) begin
                    bus.lsu_rsp_valid = 1'b1;
                    bus.lsu_rdata     = DW'(rdata_q);
                end else begin
                    bus.ifu_rsp_valid = 1'b1;
                    bus.ifu_rdata     = DW'(rdata_q);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Latched address/data stay visible for the whole transaction, zero while idle.
        if (state_q != IDLE) begin
            if (req_q.wen) begin
                bus.mem_waddr = AW'(req_q.addr);
                bus.mem_wdata = DW'(req_q.wdata);
                bus.mem_wmask = (DW/8)'(req_q.wmask);
            end else begin
                bus.mem_raddr = AW'(req_q.addr);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance at LATENCY=2 and one at LATENCY=0.
// Expected accesses/responses are queued at each handshake and retired when the DUT produces them.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        int            start;
    } stim_t;

    typedef struct {
        logic          src;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        logic [DW-1:0] rdata;
        int            acc_cyc;
        int            rsp_cyc;
    } exp_t;

    typedef struct {
        logic src;
        int   cyc;
    } grant_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic          ifu_v  [N];
    logic [AW-1:0] ifu_a  [N];
    logic          lsu_v  [N];
    logic [AW-1:0] lsu_a  [N];
    logic          lsu_we [N];
    logic [DW-1:0] lsu_wd [N];
    logic [MW-1:0] lsu_wm [N];

    logic          ifu_rdy [N];
    logic          lsu_rdy [N];
    logic          ifu_rv  [N];
    logic          lsu_rv  [N];
    logic [DW-1:0] ifu_rd  [N];
    logic [DW-1:0] lsu_rd  [N];
    logic          mren    [N];
    logic          mwen    [N];
    logic [AW-1:0] mraddr  [N];
    logic [AW-1:0] mwaddr  [N];
    logic [DW-1:0] mwdata  [N];
    logic [MW-1:0] mwmask  [N];

    stim_t  ifu_pend [N][$];
    stim_t  lsu_pend [N][$];
    exp_t   acc_q    [N][$];
    exp_t   rsp_q    [N][$];
    grant_t glog     [N][$];
    logic   hs_ifu   [N];
    logic   hs_lsu   [N];

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_DEAD_BEEF;
        return {a[31:0] ^ 32'hA5A5_0F0F, ~a[31:0]};
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

        assign bus.ifu_req_valid = ifu_v[gi];
        assign bus.ifu_addr      = ifu_a[gi];
        assign bus.lsu_req_valid = lsu_v[gi];
        assign bus.lsu_addr      = lsu_a[gi];
        assign bus.lsu_wen       = lsu_we[gi];
        assign bus.lsu_wdata     = lsu_wd[gi];
        assign bus.lsu_wmask     = lsu_wm[gi];
        assign bus.mem_rdata     = mem_fn(bus.mem_raddr);

        assign ifu_rdy[gi] = bus.ifu_req_ready;
        assign lsu_rdy[gi] = bus.lsu_req_ready;
        assign ifu_rv[gi]  = bus.ifu_rsp_valid;
        assign lsu_rv[gi]  = bus.lsu_rsp_valid;
        assign ifu_rd[gi]  = bus.ifu_rdata;
        assign lsu_rd[gi]  = bus.lsu_rdata;
        assign mren[gi]    = bus.mem_ren;
        assign mwen[gi]    = bus.mem_wen;
        assign mraddr[gi]  = bus.mem_raddr;
        assign mwaddr[gi]  = bus.mem_waddr;
        assign mwdata[gi]  = bus.mem_wdata;
        assign mwmask[gi]  = bus.mem_wmask;

        mem_arbiter #(
            .LATENCY (gi == 0 ? 2 : 0),
            .AW      (AW),
            .DW      (DW)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor(input int i);
        exp_t  e;
        string p;
        p = $sformatf("u%0d.", i);
        hs_ifu[i] = ifu_v[i] & ifu_rdy[i];
        hs_lsu[i] = lsu_v[i] & lsu_rdy[i];
        if (ifu_rdy[i] || lsu_rdy[i])
            check({p, "single_ready"}, 64'(ifu_rdy[i] & lsu_rdy[i]), 64'd0);
        if (hs_lsu[i] || hs_ifu[i]) begin
            e.src     = hs_lsu[i];
            e.wen     = hs_lsu[i] ? lsu_we[i] : 1'b0;
            e.addr    = hs_lsu[i] ? lsu_a[i] : ifu_a[i];
            e.wdata   = hs_lsu[i] ? lsu_wd[i] : '0;
            e.wmask   = hs_lsu[i] ? lsu_wm[i] : '0;
            e.rdata   = e.wen ? '0 : mem_fn(e.addr);
            e.acc_cyc = cyc + 1 + lat_of(i);
            e.rsp_cyc = cyc + 2 + lat_of(i);
            acc_q[i].push_back(e);
            rsp_q[i].push_back(e);
            glog[i].push_back('{src: e.src, cyc: cyc});
        end

        if (mren[i] || mwen[i]) begin
            if (acc_q[i].size() == 0) begin
                check({p, "stray_strobe"}, 64'(mren[i] | mwen[i]), 64'd0);
            end else begin
                e = acc_q[i].pop_front();
                check({p, "acc_cycle"}, 64'(cyc), 64'(e.acc_cyc));
                check({p, "mem_ren"}, 64'(mren[i]), 64'(!e.wen));
                check({p, "mem_wen"}, 64'(mwen[i]), 64'(e.wen));
                if (e.wen) begin
                    check({p, "mem_waddr"}, mwaddr[i], e.addr);
                    check({p, "mem_wdata"}, mwdata[i], e.wdata);
                    check({p, "mem_wmask"}, 64'(mwmask[i]), 64'(e.wmask));
                end else begin
                    check({p, "mem_raddr"}, mraddr[i], e.addr);
                end
            end
        end else if (acc_q[i].size() != 0 && acc_q[i][0].acc_cyc <= cyc) begin
            check({p, "acc_missing"}, 64'(mren[i] | mwen[i]), 64'd1);
            void'(acc_q[i].pop_front());
        end

        if (ifu_rv[i] || lsu_rv[i]) begin
            check({p, "dual_rsp"}, 64'(ifu_rv[i] & lsu_rv[i]), 64'd0);
            if (rsp_q[i].size() == 0) begin
                check({p, "stray_rsp"}, 64'(ifu_rv[i] | lsu_rv[i]), 64'd0);
            end else begin
                e = rsp_q[i].pop_front();
                check({p, "rsp_cycle"}, 64'(cyc), 64'(e.rsp_cyc));
                check({p, "rsp_src"}, 64'(lsu_rv[i]), 64'(e.src));
                check({p, "rsp_rdata"}, e.src ? lsu_rd[i] : ifu_rd[i], e.rdata);
                check({p, "other_rdata"}, e.src ? ifu_rd[i] : lsu_rd[i], 64'd0);
                $display("u%0d rsp %s %s addr=%h rdata=%h cycle=%0d", i, e.src ? "LSU" : "IFU",
                         e.wen ? "WR" : "RD", e.addr, e.src ? lsu_rd[i] : ifu_rd[i], cyc);
            end
        end else begin
            check({p, "idle_rdata"}, ifu_rd[i] | lsu_rd[i], 64'd0);
            if (rsp_q[i].size() != 0 && rsp_q[i][0].rsp_cyc <= cyc) begin
                check({p, "rsp_missing"}, 64'(ifu_rv[i] | lsu_rv[i]), 64'd1);
                void'(rsp_q[i].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) monitor(i);
        end
    end

    // Requester model: keeps valid and payload stable until the handshake, then loads the next request.
    initial begin : driver
        stim_t s;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs_ifu[i]) begin ifu_v[i] = 1'b0; hs_ifu[i] = 1'b0; end
                if (hs_lsu[i]) begin lsu_v[i] = 1'b0; hs_lsu[i] = 1'b0; end
                if (!ifu_v[i] && ifu_pend[i].size() != 0 && ifu_pend[i][0].start <= cyc) begin
                    s = ifu_pend[i].pop_front();
                    ifu_v[i] = 1'b1;
                    ifu_a[i] = s.addr;
                end
                if (!lsu_v[i] && lsu_pend[i].size() != 0 && lsu_pend[i][0].start <= cyc) begin
                    s = lsu_pend[i].pop_front();
                    lsu_v[i]  = 1'b1;
                    lsu_a[i]  = s.addr;
                    lsu_we[i] = s.wen;
                    lsu_wd[i] = s.wdata;
                    lsu_wm[i] = s.wmask;
                end
            end
        end
    end

    task automatic push_ifu(input int i, input logic [AW-1:0] a, input int start);
        ifu_pend[i].push_back('{wen: 1'b0, addr: a, wdata: '0, wmask: '0, start: start});
    endtask

    task automatic push_lsu(input int i, input logic [AW-1:0] a, input logic we,
                            input logic [DW-1:0] wd, input logic [MW-1:0] wm, input int start);
        lsu_pend[i].push_back('{wen: we, addr: a, wdata: wd, wmask: wm, start: start});
    endtask

    function automatic int pending_count(input int i);
        return ifu_pend[i].size() + lsu_pend[i].size() + acc_q[i].size() + rsp_q[i].size()
               + int'(ifu_v[i]) + int'(lsu_v[i]);
    endfunction

    task automatic drain(input int i);
        int n = 0;
        while (pending_count(i) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check($sformatf("u%0d.drain_left", i), 64'(pending_count(i)), 64'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic check_grants(input int i, input int n, input logic [2:0] srcs,
                                input int c0, input int c1, input int c2);
        string p;
        int    c;
        p = $sformatf("u%0d.", i);
        check({p, "grant_count"}, 64'(glog[i].size()), 64'(n));
        for (int k = 0; k < n && k < glog[i].size(); k++) begin
            c = (k == 0) ? c0 : (k == 1) ? c1 : c2;
            check($sformatf("%sgrant%0d_src", p, k), 64'(glog[i][k].src), 64'(srcs[k]));
            check($sformatf("%sgrant%0d_cycle", p, k), 64'(glog[i][k].cyc), 64'(c));
        end
    endtask

    task automatic check_rst_zero(input string tag);
        string p;
        for (int i = 0; i < N; i++) begin
            p = $sformatf("u%0d.%s.", i, tag);
            check({p, "ifu_ready"}, 64'(ifu_rdy[i]), 64'd0);
            check({p, "lsu_ready"}, 64'(lsu_rdy[i]), 64'd0);
            check({p, "rsp_valid"}, 64'(ifu_rv[i] | lsu_rv[i]), 64'd0);
            check({p, "rdata"}, ifu_rd[i] | lsu_rd[i], 64'd0);
            check({p, "strobes"}, 64'(mren[i] | mwen[i]), 64'd0);
            check({p, "mem_raddr"}, mraddr[i], 64'd0);
            check({p, "mem_waddr"}, mwaddr[i], 64'd0);
            check({p, "mem_wdata"}, mwdata[i], 64'd0);
            check({p, "mem_wmask"}, 64'(mwmask[i]), 64'd0);
        end
    endtask

    // Called at posedge+2; reset is asserted asynchronously, mid-cycle.
    task automatic apply_reset(input string tag, input int n);
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            ifu_v[i]  = 1'b0;
            lsu_v[i]  = 1'b0;
            hs_ifu[i] = 1'b0;
            hs_lsu[i] = 1'b0;
            ifu_pend[i].delete();
            lsu_pend[i].delete();
            acc_q[i].delete();
            rsp_q[i].delete();
            glog[i].delete();
        end
        #1;
        check_rst_zero(tag);
        repeat (n) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        for (int i = 0; i < N; i++) begin
            ifu_v[i] = 1'b0; ifu_a[i] = '0; lsu_v[i] = 1'b0; lsu_a[i] = '0;
            lsu_we[i] = 1'b0; lsu_wd[i] = '0; lsu_wm[i] = '0;
            hs_ifu[i] = 1'b0; hs_lsu[i] = 1'b0;
        end
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        apply_reset("por", 2);

        // IFU read alone: ready in C, ren in C+3, response in C+4.
        base = cyc + 1;
        push_ifu(0, 64'h0000_0000_8000_0000, base);
        drain(0);
        check_grants(0, 1, 3'b000, base, 0, 0);
        glog[0].delete();

        // LSU write: one-cycle write strobe, response with zero rdata.
        base = cyc + 1;
        push_lsu(0, 64'h0000_0000_8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, base);
        drain(0);
        check_grants(0, 1, 3'b001, base, 0, 0);

        // Contention from a fresh reset: two LSU reads plus one IFU read all pending.
        @(posedge clk);
        #2;
        apply_reset("pre_arb", 2);
        base = cyc + 1;
        push_lsu(0, 64'h0000_0000_8000_0100, 1'b0, '0, '0, base);
        push_lsu(0, 64'h0000_0000_8000_0108, 1'b0, '0, '0, base);
        push_ifu(0, 64'h0000_0000_8000_0200, base);
        drain(0);
`ifdef MEM_ARB_RR_EN
        check_grants(0, 3, 3'b101, base, base + 5, base + 10);
`else
        check_grants(0, 3, 3'b011, base, base + 5, base + 10);
`endif
        glog[0].delete();

        // IFU request raised in the LSU's RESP cycle is accepted the cycle after.
        base = cyc + 1;
        push_lsu(0, 64'h0000_0000_8000_0300, 1'b1, 64'hCAFE_F00D_0BAD_BEEF, 8'hA5, base);
        push_ifu(0, 64'h0000_0000_8000_0400, base + 4);
        drain(0);
        check_grants(0, 2, 3'b001, base, base + 5, 0);

        // LATENCY=0 instance: back-to-back IFU reads every 3 cycles.
        base = cyc + 1;
        push_ifu(1, 64'h0000_0000_8000_1000, base);
        push_ifu(1, 64'h0000_0000_8000_1008, base);
        push_ifu(1, 64'h0000_0000_8000_1010, base);
        drain(1);
        check_grants(1, 3, 3'b000, base, base + 3, base + 6);

        // Reset while in WAIT aborts the transaction; the reissued request completes.
        glog[0].delete();
        base = cyc + 1;
        push_ifu(0, 64'h0000_0000_8000_0500, base);
        repeat (2) @(posedge clk);
        #2;
        apply_reset("mid_wait", 3);
        base = cyc + 1;
        push_ifu(0, 64'h0000_0000_8000_0500, base);
        drain(0);
        check_grants(0, 1, 3'b000, base, 0, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
